// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer engine: FSM states, width derivation,
// and the shift/saturate/offset mapping from accumulator to LUT address.
package layer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  typedef logic signed [63:0] wide_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic int acc_size(input int in_w, input int w_w, input int n);
    return in_w + w_w + 1 + clog2(n);
  endfunction

  // Result is the unsigned LUT address; 0 lands on the midpoint 2^(addr_size-1).
  function automatic logic [63:0] sat_offset(input wide_t acc, input int frac_shift,
                                             input int addr_size);
    wide_t s;
    wide_t hi;
    wide_t lo;
    wide_t r;
    s  = acc >>> frac_shift;
    hi = (64'sd1 <<< (addr_size - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      r = hi;
    end else if (s < lo) begin
      r = lo;
    end else begin
      r = s;
    end
    return r + hi + 64'sd1;
  endfunction

endpackage

// File: rtl/layer_mac.sv
// One neuron's multiply-accumulate: unsigned input times signed weight, summed
// into a signed accumulator sized so that a full layer can never overflow.
module layer_mac #(
  parameter int INPUT_SIZE  = 9,
  parameter int WEIGHT_SIZE = 17,
  parameter int ACC_SIZE    = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [INPUT_SIZE-1:0]      in,
  input  logic [WEIGHT_SIZE-1:0]     w,
  output logic signed [ACC_SIZE-1:0] acc
);

  localparam int PROD_SIZE = INPUT_SIZE + WEIGHT_SIZE + 1;

  logic signed [PROD_SIZE-1:0] in_ext_s;
  logic signed [PROD_SIZE-1:0] w_ext_s;
  logic signed [PROD_SIZE-1:0] prod_s;
  logic signed [ACC_SIZE-1:0]  acc_d;
  logic signed [ACC_SIZE-1:0]  acc_q;

  assign in_ext_s = $signed({{(WEIGHT_SIZE + 1){1'b0}}, in});
  assign w_ext_s  = $signed({{(INPUT_SIZE + 1){w[WEIGHT_SIZE-1]}}, w});
  assign prod_s   = in_ext_s * w_ext_s;
  assign acc      = acc_q;

  // Next accumulator value: clear has priority over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = {ACC_SIZE{1'b0}};
    end else if (en) begin
      acc_d = acc_q + ACC_SIZE'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= {ACC_SIZE{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/layer_engine.sv
// Time-multiplexed neuron array: latches one layer's operands on start, runs a
// MAC per neuron over all inputs, then registers saturated LUT addresses.
module layer_engine
  import layer_pkg::*;
#(
  parameter int NUM_NEURON  = 6,
  parameter int INPUT_SIZE  = 9,
  parameter int WEIGHT_SIZE = 17,
  parameter int ADDR_SIZE   = 10,
  parameter int FRAC_SHIFT  = 13
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      layer_start,
  input  logic [NUM_NEURON-1:0]                     active,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0]          layer_input,
  input  logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] layer_weights,
  output logic [NUM_NEURON*ADDR_SIZE-1:0]           layer_output,
  output logic [NUM_NEURON-1:0]                     layer_output_valid,
  output logic                                      busy
);

  localparam int ACC_SIZE = acc_size(INPUT_SIZE, WEIGHT_SIZE, NUM_NEURON);
  localparam int K_W      = (clog2(NUM_NEURON) > 0) ? clog2(NUM_NEURON) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_NEURON - 1);

  state_e                                       state_q;
  logic [K_W-1:0]                               k_q;
  logic [NUM_NEURON*INPUT_SIZE-1:0]             in_q;
  logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] w_q;
  logic [NUM_NEURON-1:0]                        act_q;
  logic [NUM_NEURON*ADDR_SIZE-1:0]              out_q;
  logic [NUM_NEURON-1:0]                        valid_q;
  logic                                         busy_q;

  logic [INPUT_SIZE-1:0]      in_k_s;
  logic                       clr_s;
  logic signed [ACC_SIZE-1:0] acc_s [NUM_NEURON];
  logic [NUM_NEURON*ADDR_SIZE-1:0] res_s;

  assign in_k_s = in_q[int'(k_q)*INPUT_SIZE +: INPUT_SIZE];
  assign clr_s  = (state_q == ST_IDLE) && layer_start;

  for (genvar j = 0; j < NUM_NEURON; j++) begin : g_neuron
    logic [WEIGHT_SIZE-1:0] w_k_s;
    logic                   en_s;

    assign w_k_s = w_q[(j*NUM_NEURON + int'(k_q))*WEIGHT_SIZE +: WEIGHT_SIZE];
    assign en_s  = (state_q == ST_RUN) && act_q[j];

    layer_mac #(
      .INPUT_SIZE (INPUT_SIZE),
      .WEIGHT_SIZE(WEIGHT_SIZE),
      .ACC_SIZE   (ACC_SIZE)
    ) u_mac (
      .clk(clk),
      .rst(rst),
      .clr(clr_s),
      .en (en_s),
      .in (in_k_s),
      .w  (w_k_s),
      .acc(acc_s[j])
    );
  end

  // Inactive neurons report address 0 rather than the midpoint of a zero sum.
  always_comb begin
    res_s = {(NUM_NEURON*ADDR_SIZE){1'b0}};
    for (int j = 0; j < NUM_NEURON; j++) begin
      if (act_q[j]) begin
        res_s[j*ADDR_SIZE +: ADDR_SIZE] =
          ADDR_SIZE'(sat_offset(64'(acc_s[j]), FRAC_SHIFT, ADDR_SIZE));
      end else begin
        res_s[j*ADDR_SIZE +: ADDR_SIZE] = {ADDR_SIZE{1'b0}};
      end
    end
  end

  // Control FSM with operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= {K_W{1'b0}};
      in_q    <= {(NUM_NEURON*INPUT_SIZE){1'b0}};
      w_q     <= {(NUM_NEURON*NUM_NEURON*WEIGHT_SIZE){1'b0}};
      act_q   <= {NUM_NEURON{1'b0}};
      out_q   <= {(NUM_NEURON*ADDR_SIZE){1'b0}};
      valid_q <= {NUM_NEURON{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= {NUM_NEURON{1'b0}};
          if (layer_start) begin
            in_q    <= layer_input;
            w_q     <= layer_weights;
            act_q   <= active;
            k_q     <= {K_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (k_q == K_LAST) begin
            state_q <= ST_OUT;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        ST_OUT: begin
          out_q   <= res_s;
          valid_q <= act_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= {NUM_NEURON{1'b0}};
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign layer_output       = out_q;
  assign layer_output_valid = valid_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_layer_engine.sv
// Scoreboard bench for layer_engine: two instances (FRAC_SHIFT 0 and 13) share
// stimulus; expected results are queued at start and checked at their due cycle.
module tb_layer_engine;

  localparam int N  = 6;
  localparam int IS = 9;
  localparam int WS = 17;
  localparam int AS = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              layer_start;
  logic [N-1:0]      active;
  logic [N*IS-1:0]   layer_input;
  logic [N*N*WS-1:0] layer_weights;

  logic [N*AS-1:0] a_out, b_out;
  logic [N-1:0]    a_valid, b_valid;
  logic            a_busy, b_busy;

  always #5 clk = ~clk;

  layer_engine #(.FRAC_SHIFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .layer_start(layer_start), .active(active),
    .layer_input(layer_input), .layer_weights(layer_weights),
    .layer_output(a_out), .layer_output_valid(a_valid), .busy(a_busy)
  );

  layer_engine #(.FRAC_SHIFT(13)) u_dut_b (
    .clk(clk), .rst(rst), .layer_start(layer_start), .active(active),
    .layer_input(layer_input), .layer_weights(layer_weights),
    .layer_output(b_out), .layer_output_valid(b_valid), .busy(b_busy)
  );

  typedef struct {
    int          due;
    logic [N*AS-1:0] exp_a;
    logic [N*AS-1:0] exp_b;
    logic [N-1:0]    exp_v;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [N*AS-1:0] model(input int shift, input logic [N*IS-1:0] lin,
                                            input logic [N*N*WS-1:0] lw, input logic [N-1:0] act);
    logic [N*AS-1:0] r;
    longint acc;
    longint s;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (act[j]) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          acc += longint'(lin[k*IS +: IS]) * longint'($signed(lw[(j*N+k)*WS +: WS]));
        end
        s = acc >>> shift;
        if (s > 511) s = 511;
        if (s < -512) s = -512;
        r[j*AS +: AS] = AS'(s + 512);
      end
    end
    return r;
  endfunction

  // Every non-reset cycle: due entries are compared in full, otherwise valid must be low.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        check_eq("valid_a", a_valid, e.exp_v);
        check_eq("valid_b", b_valid, e.exp_v);
        check_eq("out_a", a_out, e.exp_a);
        check_eq("out_b", b_out, e.exp_b);
        check_eq("busy_after_out", a_busy, 0);
      end else begin
        check_eq("no_valid_a", a_valid, 0);
        check_eq("no_valid_b", b_valid, 0);
      end
    end
  end

  task automatic send(input logic [N-1:0] act, input bit accept);
    exp_t e;
    active      = act;
    layer_start = 1'b1;
    if (accept) begin
      e.due   = cyc + 8;
      e.exp_a = model(0, layer_input, layer_weights, act);
      e.exp_b = model(13, layer_input, layer_weights, act);
      e.exp_v = act;
      sb_q.push_back(e);
    end
    @(negedge clk);
    layer_start = 1'b0;
    if (accept) begin
      check_eq("busy_a_after_latch", a_busy, 1);
      check_eq("busy_b_after_latch", b_busy, 1);
    end
  endtask

  task automatic set_in_const(input int v);
    for (int k = 0; k < N; k++) layer_input[k*IS +: IS] = IS'(v);
  endtask

  task automatic set_w_const(input int v);
    for (int i = 0; i < N*N; i++) layer_weights[i*WS +: WS] = WS'(v);
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) layer_input[k*IS +: IS] = IS'($urandom_range(0, 511));
    for (int i = 0; i < N*N; i++) layer_weights[i*WS +: WS] = WS'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    layer_start = 1'b0;
    active = '0;
    layer_input = '0;
    layer_weights = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_a", a_out, 0);
    check_eq("rst_out_b", b_out, 0);
    check_eq("rst_valid_a", a_valid, 0);
    check_eq("rst_busy_a", a_busy, 0);
    check_eq("rst_busy_b", b_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // single neuron, unit data
    set_in_const(1);
    set_w_const(0);
    for (int k = 0; k < N; k++) layer_weights[k*WS +: WS] = WS'(1);
    send(6'b000001, 1'b1);
    repeat (10) @(negedge clk);

    // positive then negative saturation
    set_in_const(511);
    set_w_const(65535);
    send(6'b111111, 1'b1);
    repeat (10) @(negedge clk);
    set_w_const(-65536);
    send(6'b111111, 1'b1);
    repeat (10) @(negedge clk);

    // ramp inputs, per-neuron negative weights
    for (int k = 0; k < N; k++) layer_input[k*IS +: IS] = IS'(k + 1);
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++) layer_weights[(j*N+k)*WS +: WS] = WS'(-(j + 1));
    send(6'b111111, 1'b1);
    repeat (10) @(negedge clk);

    // no active neurons
    send(6'b000000, 1'b1);
    repeat (10) @(negedge clk);

    // start while busy is ignored and operand changes do not leak in
    rand_data();
    send(6'b101101, 1'b1);
    repeat (2) @(negedge clk);
    rand_data();
    send(6'b111111, 1'b0);
    repeat (10) @(negedge clk);

    // back-to-back: second start in the valid cycle
    rand_data();
    send(6'b111111, 1'b1);
    repeat (7) @(negedge clk);
    rand_data();
    send(6'b110011, 1'b1);
    repeat (10) @(negedge clk);

    // reset during RUN at k=3
    rand_data();
    send(6'b111111, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy_a", a_busy, 0);
    check_eq("abort_busy_b", b_busy, 0);
    check_eq("abort_out_a", a_out, 0);
    check_eq("abort_out_b", b_out, 0);
    check_eq("abort_valid_a", a_valid, 0);
    repeat (10) @(negedge clk);
    for (int k = 0; k < N; k++) layer_input[k*IS +: IS] = IS'(k + 1);
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++) layer_weights[(j*N+k)*WS +: WS] = WS'(j + 1);
    send(6'b111111, 1'b1);
    repeat (10) @(negedge clk);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_engine.md
Name: layer_engine

Overview:
- Neuron-array datapath on the far side of the layer controller; one instance is time-multiplexed across all network layers.
- Accepts a start pulse, a per-neuron active mask, NUM_NEURON inputs and a NUM_NEURON x NUM_NEURON weight matrix.
- Each active neuron computes a sequential multiply-accumulate dot product.
- Returns one activation-LUT address per neuron with per-neuron valid, in the form the output aggregator consumes.

Parameters:
- NUM_NEURON, 6, number of neurons and number of inputs per neuron
- INPUT_SIZE, 9, width of each input value (unsigned)
- WEIGHT_SIZE, 17, width of each weight (signed two's complement)
- ADDR_SIZE, 10, width of each output LUT address
- FRAC_SHIFT, 13, arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- layer_start  input  1  start pulse from the controller
- active  input  NUM_NEURON  neuron enable mask; bit j enables neuron j
- layer_input  input  NUM_NEURON*INPUT_SIZE  input k at [k*INPUT_SIZE +: INPUT_SIZE]
- layer_weights  input  NUM_NEURON*NUM_NEURON*WEIGHT_SIZE  weight (neuron j, input k) at [(j*NUM_NEURON+k)*WEIGHT_SIZE +: WEIGHT_SIZE]
- layer_output  output  NUM_NEURON*ADDR_SIZE  LUT address for neuron j at [j*ADDR_SIZE +: ADDR_SIZE]
- layer_output_valid  output  NUM_NEURON  per-neuron output valid
- busy  output  1  high from the latch cycle through the OUT cycle

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: state=IDLE; accumulators, layer_output, layer_output_valid and busy all 0.
- States: IDLE -> LOAD -> RUN -> OUT -> IDLE.
- IDLE:
  - Sampling layer_start=1 at edge 0 latches layer_input, layer_weights and active into registers, clears the accumulators, sets k=0 and moves to RUN.
  - busy=1 after edge 0.
  - LOAD is this latch edge, not a separate cycle.
- RUN: NUM_NEURON cycles, k=0..NUM_NEURON-1.
  - Each edge, for each latched-active neuron j: acc_j += $unsigned(in_k) * $signed(w_jk).
  - Inactive neurons keep acc=0.
  - Move to OUT when k==NUM_NEURON-1; k does not wrap.
- Product width: INPUT_SIZE+WEIGHT_SIZE+1 signed (input zero-extended).
- Accumulator width: ACC_SIZE = INPUT_SIZE+WEIGHT_SIZE+1+clog2(NUM_NEURON); no overflow is possible.
- OUT: a single cycle that registers the outputs.
  - s = acc_j >>> FRAC_SHIFT (arithmetic).
  - Saturate s to the signed ADDR_SIZE range [-2^(ADDR_SIZE-1), 2^(ADDR_SIZE-1)-1].
  - layer_output_j = s_sat + 2^(ADDR_SIZE-1): an unsigned address, 0 maps to the LUT midpoint 512.
  - layer_output_valid_j = latched active_j.
  - Return to IDLE.
- Output timing:
  - layer_output_valid is a one-cycle pulse, visible for exactly the cycle after the OUT edge.
  - Latency from the layer_start sample edge to valid = NUM_NEURON+1 edges (7 at default).
  - layer_output holds its value until the next OUT; inactive neurons output 0.
- Back-to-back: layer_start is accepted in the same cycle valid is high (state already IDLE), so a layer can start every NUM_NEURON+2 cycles.
- layer_start while busy: ignored, with no effect on latched data.
- Input/weight/active changes after the latch edge: no effect on the current computation.
- active all zero: the engine still runs the full sequence; layer_output_valid=0 for every neuron in OUT.
- rst mid-operation: abort to IDLE the next edge, with no valid pulse and outputs cleared.

Decomposition:
- Package layer_pkg: clog2 function, ACC_SIZE derivation, saturate-and-offset function (acc, FRAC_SHIFT, ADDR_SIZE).
- Sub-module layer_mac, one instance per neuron via generate:
  - ports: clk, rst, clr, en, in (INPUT_SIZE), w (WEIGHT_SIZE), acc (ACC_SIZE)
  - top level holds the FSM, the k counter, the weight/input mux and the output registers.

Test Plan:
1. FRAC_SHIFT=0; all inputs 1; neuron 0 weights all 1; active=6'b000001; start pulse -> exactly 7 edges later valid=000001 for one cycle; out0=518; other outputs 0.
2. Default FRAC_SHIFT=13; inputs all 511; weights all +65535; active all ones -> every output=1023 (positive saturation). Repeat with weights all -65536 -> every output=0 (negative saturation).
3. FRAC_SHIFT=0; input k=k+1; neuron j weights = -(j+1) -> out_j = 512 - 21(j+1), i.e. 491, 470, 449, 428, 407, 386.
4. Second start pulse 3 cycles after the first, with different inputs -> ignored; only one valid pulse, carrying the first inputs' results.
5. Start pulse asserted in the same cycle as valid (back-to-back) -> second result's valid arrives 7 edges later, correct for the second data set.
6. rst asserted at RUN k=3 -> no valid pulse; outputs 0; busy=0 next cycle; a subsequent start computes correctly from zero accumulators.
